sram_controller: RTL and testbench
==================================

# sram_controller

Data-memory backend for the 5-stage ARM pipeline. It sits directly downstream of the MEM stage and replaces its on-chip data array with an external 16-bit asynchronous SRAM (256K x 16). Each 32-bit load or store becomes two halfword SRAM transactions. While a request is in flight, `ready` is held low; the pipeline combines `~ready` with the hazard freeze to stall all stages.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: cycles per halfword phase. Legal values are 2 to 15.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wrEn`  in  1  store request from MEM stage.
- `rdEn`  in  1  load request from MEM stage.
- `address`  in  32  byte address (ALU result).
- `writeData`  in  32  store data (Rm value).
- `readData`  out  32  load result, registered.
- `ready`  out  1  request complete, or no request pending.
- `sramDq`  inout  16  SRAM data bus.
- `sramAddr`  out  18  SRAM halfword address.
- `sramUbN`, `sramLbN`  out  1  byte enables, active low.
- `sramCeN`, `sramOeN`, `sramWeN`  out  1  chip enable, output enable, write enable; all active low.

## Operation
- Address mapping:
  - `wordAddr = (address - BASE_ADDR) >> 2`, computed modulo 2^32 and truncated to 17 bits.
  - `address[1:0]` is ignored.
  - `sramAddr = {wordAddr, half}`, where `half` is 0 for bits [15:0] and 1 for bits [31:16].
- Request capture:
  - In IDLE, `address`, `writeData` and the operation type are registered when `rdEn | wrEn` is high.
  - If both are high, the request is treated as a write.
- State machine:
  - IDLE: if a request is present, go to LOW and clear the counter; otherwise stay.
  - LOW: access `half`=0 for `ACCESS_CYCLES` cycles, then go to HIGH with the counter cleared.
  - HIGH: access `half`=1 for `ACCESS_CYCLES` cycles, then go to DONE.
  - DONE: lasts one cycle, then go to IDLE unconditionally.
- `ready = (state==IDLE & ~rdEn & ~wrEn) | (state==DONE)`. This is a combinational path from the request inputs.
- During LOW and HIGH:
  - `sramCeN`, `sramUbN` and `sramLbN` are 0.
  - `sramAddr` holds for the whole phase.
- Write phase:
  - `sramDq` drives the latched halfword for the whole phase.
  - `sramWeN`=0 for phase cycles 0..ACCESS_CYCLES-2.
  - `sramWeN`=1 on the last cycle of the phase, which gives data/address hold.
  - `sramOeN`=1.
- Read phase:
  - `sramDq` is high-Z and `sramOeN`=0 for the whole phase.
  - `sramDq` is sampled into `readData[15:0]` (LOW) or `readData[31:16]` (HIGH) on the clock edge that ends the phase.
- In IDLE and DONE:
  - `sramCeN`, `sramOeN`, `sramWeN`, `sramUbN` and `sramLbN` are all 1.
  - `sramDq` is high-Z.
  - `sramAddr` keeps its last value.
- `readData` holds its value until the next read overwrites it. A write does not alter `readData`.
- SRAM control outputs are decoded from the state and counter registers only, never from the inputs.

## Timing
- Reset values:
  - State IDLE; counter 0.
  - `readData`=0, `sramAddr`=0.
  - `sramCeN`/`sramOeN`/`sramWeN`/`sramUbN`/`sramLbN`=1.
  - `sramDq` high-Z.
  - `ready` = `~(rdEn|wrEn)`.
- Latency:
  - A request is first seen in IDLE in cycle t0.
  - LOW occupies cycles t0+1..t0+N, HIGH occupies t0+N+1..t0+2N, DONE is cycle t0+2N+1 (N = `ACCESS_CYCLES`).
  - `ready`=1 only in t0+2N+1, so N=2 gives 5 stall cycles.
  - `readData` is valid from t0+2N+1 onward.
- A request held into DONE is not restarted; DONE always returns to IDLE.
- A request present in the IDLE cycle immediately following DONE starts a new access. Back-to-back requests therefore cost 2N+2 cycles each.
- Request inputs are ignored outside IDLE; the latched copies are used.
- Reset asserted mid-access:
  - Immediate return to IDLE.
  - `sramWeN`=1 and bus released in the same cycle, asynchronously.
  - A partially written word may remain in the SRAM; no completion is signalled.
- The address wraps silently: `address`=0 maps to word (2^32-1024)/4 truncated to 17 bits, which is 0x1FF00.

## Test plan
- Idle, no request: `ready`=1 and all SRAM strobes are 1 for 10 cycles; after reset, `readData`=0.
- Write, then read back:
  - Stimulus: `wrEn` with `address`=1024, `writeData`=0xDEADBEEF, then `rdEn` at 1024.
  - Required on the write: `sramAddr`=0 with `sramDq`=0xBEEF, then `sramAddr`=1 with `sramDq`=0xDEAD.
  - Required on the read: `readData`=0xDEADBEEF.
- Latency, N=2 and N=4:
  - Stimulus: `rdEn` at 1032.
  - Required: `sramAddr` steps 4 then 5; `ready` rises exactly 5 and 9 cycles after the request cycle respectively, for exactly 1 cycle.
- Simultaneous `rdEn`=`wrEn`=1 at 1028 with data 0x12345678:
  - Required: treated as a write; a subsequent read returns 0x12345678.
  - Required: `readData` is unchanged by the write.
- Reset mid-write:
  - Stimulus: `rst` asserted in the HIGH phase.
  - Required: `sramWeN`=1 and `sramDq`=Z in the same cycle; state IDLE; `ready` follows the request inputs.
  - Required: a read at the same address afterwards returns the new low half and the old high half.
- Back-to-back: a store then a load issued on consecutive pipeline advances each complete, with exactly one IDLE cycle between DONE and the next LOW.

Source files
------------

// File: rtl/sram_controller.sv
// 32-bit load/store backend for a 16-bit asynchronous SRAM: every request is
// split into a low-halfword phase and a high-halfword phase of ACCESS_CYCLES each.
module sram_controller #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] sramDq,
  output logic [17:0] sramAddr,
  output logic        sramUbN,
  output logic        sramLbN,
  output logic        sramCeN,
  output logic        sramOeN,
  output logic        sramWeN
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;

  logic        request;
  logic        phase_last;
  logic [16:0] word_in;
  logic        drive_en;
  logic [15:0] drive_data;

  assign request    = rdEn | wrEn;
  assign phase_last = (cnt_q == LAST_CNT);
  // Offset arithmetic wraps modulo 2^32, so addresses below the base alias high words.
  assign word_in    = 17'((address - BASE_ADDR) >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (request) begin
          state_d = LOW;
          word_d  = word_in;
          wdata_d = writeData;
          write_d = wrEn;
          addr_d  = {word_in, 1'b0};
        end
      end
      LOW: begin
        if (phase_last) begin
          state_d = HIGH;
          cnt_d   = '0;
          addr_d  = {word_q, 1'b1};
          if (!write_q) rdata_d[15:0] = sramDq;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (phase_last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!write_q) rdata_d[31:16] = sramDq;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes depend only on registered state so reset releases the bus immediately.
  always_comb begin
    sramCeN    = 1'b1;
    sramOeN    = 1'b1;
    sramWeN    = 1'b1;
    sramUbN    = 1'b1;
    sramLbN    = 1'b1;
    drive_en   = 1'b0;
    drive_data = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
    if (state_q == LOW || state_q == HIGH) begin
      sramCeN = 1'b0;
      sramUbN = 1'b0;
      sramLbN = 1'b0;
      if (write_q) begin
        drive_en = 1'b1;
        sramWeN  = phase_last;
      end else begin
        sramOeN = 1'b0;
      end
    end
  end

  assign sramDq   = drive_en ? drive_data : 16'hzzzz;
  assign ready    = ((state_q == IDLE) && !request) || (state_q == DONE);
  assign readData = rdata_q;
  assign sramAddr = addr_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a word-level reference memory predicts every load,
// and each transaction's SRAM bus activity is checked cycle by cycle.
module tb_sram_controller;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         ub_n, lb_n, ce_n, oe_n, we_n;

  logic        wr4, rd4;
  logic [31:0] addr4, wdata4;
  wire  [31:0] read_data4;
  wire         ready4;
  wire  [15:0] sram_dq4;
  wire  [17:0] sram_addr4;
  wire         ub4_n, lb4_n, ce4_n, oe4_n, we4_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_controller #(.ACCESS_CYCLES(N), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .wrEn(wr_en), .rdEn(rd_en), .address(address),
    .writeData(write_data), .readData(read_data), .ready(ready), .sramDq(sram_dq),
    .sramAddr(sram_addr), .sramUbN(ub_n), .sramLbN(lb_n), .sramCeN(ce_n),
    .sramOeN(oe_n), .sramWeN(we_n)
  );

  sram_controller #(.ACCESS_CYCLES(4), .BASE_ADDR(32'd1024)) dut4 (
    .clk(clk), .rst(rst), .wrEn(wr4), .rdEn(rd4), .address(addr4),
    .writeData(wdata4), .readData(read_data4), .ready(ready4), .sramDq(sram_dq4),
    .sramAddr(sram_addr4), .sramUbN(ub4_n), .sramLbN(lb4_n), .sramCeN(ce4_n),
    .sramOeN(oe4_n), .sramWeN(we4_n)
  );

  // External SRAM model; released bus floats high so a driven-vs-released bus is visible.
  logic [15:0] sram_mem [0:262143];
  assign sram_dq = (!ce_n && !oe_n) ? sram_mem[sram_addr] : 16'hzzzz;
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
      pullup pu (sram_dq[gi]);
    end
  endgenerate
  always @(negedge clk) begin
    if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq;
  end

  // The second instance reads a pattern derived from its own address.
  assign sram_dq4 = (!ce4_n && !oe4_n) ? ~sram_addr4[15:0] : 16'hzzzz;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd;
  logic [31:0] written_q [$];

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'd1024;
    return d[18:2];
  endfunction

  task automatic do_op(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                       input logic [31:0] data, input string tag);
    logic [16:0] w;
    logic [4:0]  exp_str, got_str;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    bit          phase, half;
    int          cnt;
    w = word_of(addr);
    @(negedge clk);
    wr_en      = is_wr;
    rd_en      = is_wr ? also_rd : 1'b1;
    address    = addr;
    write_data = data;
    #1;
    n_checks++;
    if (ready !== 1'b0 || ce_n !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start: ready=%b ce_n=%b, required ready=0 ce_n=1", tag, ready, ce_n);
    end
    if (is_wr) ref_mem[w] = data;
    else       ref_rd = ref_mem.exists(int'(w)) ? ref_mem[w] : 32'h0;
    for (int k = 1; k <= 2 * N + 1; k++) begin
      @(negedge clk);
      phase    = (k <= 2 * N);
      half     = (k > N);
      cnt      = half ? k - N - 1 : k - 1;
      exp_addr = {w, half};
      exp_str  = {!phase, !(!is_wr && phase), !(is_wr && phase && cnt != N - 1),
                  !phase, !phase};
      got_str  = {ce_n, oe_n, we_n, ub_n, lb_n};
      n_checks++;
      if (got_str !== exp_str || sram_addr !== exp_addr || ready !== (k == 2 * N + 1)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: strobes=%b addr=%h ready=%b, required strobes=%b addr=%h ready=%b",
                 tag, k, got_str, sram_addr, ready, exp_str, exp_addr, (k == 2 * N + 1));
      end
      if (!phase || is_wr) begin
        exp_dq = !phase ? 16'hFFFF : (half ? data[31:16] : data[15:0]);
        n_checks++;
        if (sram_dq !== exp_dq) begin
          n_fail++;
          $display("FAIL %s dq cycle %0d: got %h, required %h", tag, k, sram_dq, exp_dq);
        end
      end
      if (k == 2 * N + 1) begin
        n_checks++;
        if (read_data !== ref_rd) begin
          n_fail++;
          $display("FAIL %s readData: got %h, required %h", tag, read_data, ref_rd);
        end
        // Request held into DONE must not restart an access.
        wr_en = 1'($urandom);
        rd_en = 1'b1;
      end else begin
        wr_en      = 1'($urandom);
        rd_en      = 1'($urandom);
        address    = $urandom;
        write_data = $urandom;
      end
    end
    $display("%s: %s addr=%h word=%h data=%h readData=%h", tag, is_wr ? "WR" : "RD",
             addr, w, is_wr ? data : ref_rd, read_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #1;
      n_checks++;
      if (ready !== 1'b1 || {ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111 || sram_dq !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL idle: ready=%b strobes=%b dq=%h, required ready=1 strobes=11111 dq=ffff",
                 ready, {ce_n, oe_n, we_n, ub_n, lb_n}, sram_dq);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    wr4 = 1'b0; rd4 = 1'b0; addr4 = '0; wdata4 = '0;
    ref_rd = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || read_data !== 32'h0 || sram_addr !== 18'h0 ||
        {ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111 || sram_dq !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset: ready=%b readData=%h addr=%h strobes=%b dq=%h, required 1/0/0/11111/ffff",
               ready, read_data, sram_addr, {ce_n, oe_n, we_n, ub_n, lb_n}, sram_dq);
    end
    rd_en = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ready follows rdEn: got %b, required 0", ready);
    end
    rd_en = 1'b0;
    rst = 1'b0;
    idle(10);
    $display("reset: idle checks complete");
  endtask

  task automatic test_write_read();
    do_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "wr_rd");
    do_op(1'b0, 1'b0, 32'd1024, 32'h0, "wr_rd");
    written_q.push_back(32'd1024);
    idle(2);
  endtask

  task automatic test_latency_n2();
    do_op(1'b1, 1'b0, 32'd1032, 32'hA5C3_0F1E, "lat2");
    idle(1);
    do_op(1'b0, 1'b0, 32'd1032, 32'h0, "lat2");
    written_q.push_back(32'd1032);
    idle(1);
  endtask

  task automatic test_latency_n4();
    logic [17:0] exp_addr;
    @(negedge clk);
    rd4   = 1'b1;
    addr4 = 32'd1032;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_addr = (k <= 4) ? 18'd4 : 18'd5;
      n_checks++;
      if (ready4 !== (k == 9) || sram_addr4 !== exp_addr || ce4_n !== (k >= 9)) begin
        n_fail++;
        $display("FAIL lat4 cycle %0d: ready=%b addr=%h ce_n=%b, required ready=%b addr=%h ce_n=%b",
                 k, ready4, sram_addr4, ce4_n, (k == 9), exp_addr, (k >= 9));
      end
      if (k == 9) begin
        n_checks++;
        if (read_data4 !== 32'hFFFAFFFB) begin
          n_fail++;
          $display("FAIL lat4 readData: got %h, required fffafffb", read_data4);
        end
      end
    end
    rd4 = 1'b0;
    $display("lat4: RD addr=00000408 readData=%h", read_data4);
  endtask

  task automatic test_simultaneous();
    do_op(1'b1, 1'b1, 32'd1028, 32'h12345678, "both");
    do_op(1'b0, 1'b0, 32'd1028, 32'h0, "both");
    written_q.push_back(32'd1028);
    idle(1);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a;
    logic [16:0] w;
    a = 32'd1024 + 32'd64;
    w = word_of(a);
    do_op(1'b1, 1'b0, a, 32'hAAAA5555, "rstmid");
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; address = a; write_data = 32'hCAFEF00D;
    repeat (N) begin
      @(negedge clk);
      wr_en = 1'b0;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (we_n !== 1'b1 || ce_n !== 1'b1 || sram_dq !== 16'hFFFF || ready !== 1'b1 ||
        read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid release: we_n=%b ce_n=%b dq=%h ready=%b readData=%h, required 1/1/ffff/1/0",
               we_n, ce_n, sram_dq, ready, read_data);
    end
    rd_en = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid ready follows rdEn: got %b, required 0", ready);
    end
    rd_en = 1'b0;
    ref_mem[w] = 32'hAAAAF00D;
    ref_rd     = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    written_q.push_back(a);
    do_op(1'b0, 1'b0, a, 32'h0, "rstmid");
    idle(1);
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 1'b0, 32'd1040, 32'h0BADF00D, "b2b");
    do_op(1'b0, 1'b0, 32'd1040, 32'h0, "b2b");
    written_q.push_back(32'd1040);
    idle(1);
  endtask

  task automatic test_wrap();
    do_op(1'b1, 1'b0, 32'd0, 32'h5A5A_C3C3, "wrap");
    do_op(1'b0, 1'b0, 32'd2, 32'h0, "wrap");
    written_q.push_back(32'd0);
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      if (written_q.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = 32'd1024 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
        do_op(1'b1, 1'($urandom), a, $urandom, "rand");
        written_q.push_back(a);
      end else begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        do_op(1'b0, 1'b0, a ^ 32'($urandom_range(0, 3)), 32'h0, "rand");
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_latency_n2();
    test_latency_n4();
    test_simultaneous();
    test_reset_mid_write();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
